// File: rtl/debug_dump_uart_if.sv
// rtl/debug_dump_uart_if.sv - debug port bundle between the dump engine and the processor
interface debug_dump_uart_if;
  logic [3:0]  debug_reg_select;
  logic [31:0] debug_reg_out;
  logic [3:0]  fsm_state;
  logic [31:0] fetch_pc;

  modport master (output debug_reg_select, input debug_reg_out, input fsm_state, input fetch_pc);
  modport slave  (input debug_reg_select, output debug_reg_out, output fsm_state, output fetch_pc);
endinterface

// File: rtl/debug_dump_uart.sv
// rtl/debug_dump_uart.sv - captures PC and registers through the debug port and streams an 8N1 frame
module debug_dump_uart #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         NUM_REGS     = 16,
  parameter logic [3:0] FETCH_STATE  = 4'd0,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dump_req,
  debug_dump_uart_if.master  dbg,
  output logic               uart_tx,
  output logic               busy,
  output logic               frame_done
);
  localparam int            CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_WORD = 5'(NUM_REGS);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_FETCH = 3'd1;
  localparam logic [2:0] S_SEND       = 3'd2;
  localparam logic [2:0] S_SELECT     = 3'd3;
  localparam logic [2:0] S_SAMPLE     = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [1:0]    byte_idx;
  logic [4:0]    word_idx;
  logic          in_sync;
  logic [7:0]    tx_byte;
  logic [31:0]   word_q;
  logic [3:0]    reg_select;
  logic          bit_end;

  assign bit_end              = (clk_cnt == LAST_CLK);
  assign busy                 = (state != S_IDLE);
  assign dbg.debug_reg_select = reg_select;

  // bit_cnt 0 is the start bit, 1..8 data (tx_byte shifts right), 9 the stop bit
  always_comb begin
    uart_tx = 1'b1;
    if (state == S_SEND) begin
      if (bit_cnt == 4'd0)
        uart_tx = 1'b0;
      else if (bit_cnt != 4'd9)
        uart_tx = tx_byte[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= 4'd0;
      byte_idx   <= 2'd0;
      word_idx   <= 5'd0;
      in_sync    <= 1'b0;
      tx_byte    <= 8'h00;
      word_q     <= 32'h0;
      reg_select <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dump_req) begin
            state      <= S_WAIT_FETCH;
            reg_select <= 4'd0;
          end
        end
        S_WAIT_FETCH: begin
          if (dbg.fsm_state == FETCH_STATE) begin
            word_q   <= dbg.fetch_pc;
            tx_byte  <= SYNC_BYTE;
            in_sync  <= 1'b1;
            byte_idx <= 2'd0;
            word_idx <= 5'd0;
            clk_cnt  <= '0;
            bit_cnt  <= 4'd0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (!bit_end) begin
            clk_cnt <= clk_cnt + CW'(1);
          end else begin
            clk_cnt <= '0;
            if (bit_cnt != 4'd9) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt != 4'd0)
                tx_byte <= {1'b0, tx_byte[7:1]};
            end else begin
              bit_cnt <= 4'd0;
              // the PC word follows the sync byte with no idle gap
              if (in_sync) begin
                in_sync <= 1'b0;
                tx_byte <= word_q[7:0];
              end else if (byte_idx != 2'd3) begin
                byte_idx <= byte_idx + 2'd1;
                tx_byte  <= word_q[15:8];
                word_q   <= {8'h00, word_q[31:8]};
              end else if (word_idx != LAST_WORD) begin
                reg_select <= word_idx[3:0];
                word_idx   <= word_idx + 5'd1;
                state      <= S_SELECT;
              end else begin
                frame_done <= 1'b1;
                state      <= S_IDLE;
              end
            end
          end
        end
        S_SELECT: state <= S_SAMPLE;
        S_SAMPLE: begin
          word_q   <= dbg.debug_reg_out;
          tx_byte  <= dbg.debug_reg_out[7:0];
          byte_idx <= 2'd0;
          state    <= S_SEND;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
